// File: rtl/plpa_run_sequencer.sv
// plpa_run_sequencer: issues a job of cfg_runs runs of cfg_len beats to a PE array while bounding runs in flight.
// Define PLPA_SEQ_PERF_EN to build the perf_stall_cnt stall counter; otherwise it is tied to zero.
module plpa_run_sequencer #(
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic [LEN_WIDTH-1:0] cfg_runs,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic                 iss_last,
    output logic                 iss_job_last,
    input  logic                 res_valid,
    input  logic                 res_ready,
    input  logic                 res_last,
    input  logic                 err_unalligned_data,
    input  logic                 core_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err_abort,
    output logic                 err_spurious,
    output logic [31:0]          perf_stall_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_ABORT} state_t;

    localparam int            OW      = 8;
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] len_q, runs_q, beat_cnt, run_cnt;
    logic [OW-1:0]        outstanding;

    logic cfg_fire, cfg_empty, iss_fire, run_issued, res_fire, fault, at_limit, abort_enter;

    assign cfg_fire    = cfg_valid & cfg_ready;
    assign cfg_empty   = (cfg_len == '0) | (cfg_runs == '0);
    assign iss_fire    = iss_valid & iss_ready;
    assign run_issued  = iss_fire & iss_last;
    assign res_fire    = res_valid & res_ready & res_last;
    assign fault       = err_unalligned_data | core_rst;
    assign at_limit    = (outstanding == MAX_OUT);
    assign abort_enter = fault & ((state == S_ISSUE) | (state == S_DRAIN));

    // NOTE: asynchronous active-low reset lets the sequencer drop a job the instant rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state <= state_nxt;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (cfg_fire) state_nxt = cfg_empty ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                if (fault)                         state_nxt = S_ABORT;
                else if (iss_fire && iss_job_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (fault)                    state_nxt = S_ABORT;
                else if (outstanding == '0)   state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: if (!fault) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // iss_valid depends only on registered state, never on iss_ready.
    always_comb begin
        cfg_ready    = 1'b0;
        iss_valid    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state)
            S_IDLE:           cfg_ready = 1'b1;
            S_ISSUE: begin
                busy      = 1'b1;
                iss_valid = ~at_limit;
            end
            S_DRAIN, S_ABORT: busy = 1'b1;
            S_DONE:           done = 1'b1;
            default:          cfg_ready = 1'b0;
        endcase
        iss_last     = iss_valid & (beat_cnt == len_q - LEN_WIDTH'(1));
        iss_job_last = iss_last & (run_cnt == runs_q - LEN_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            runs_q   <= '0;
            beat_cnt <= '0;
            run_cnt  <= '0;
        end else if (cfg_fire) begin
            len_q    <= cfg_len;
            runs_q   <= cfg_runs;
            beat_cnt <= '0;
            run_cnt  <= '0;
        end else if (iss_fire) begin
            beat_cnt <= iss_last ? '0 : beat_cnt + LEN_WIDTH'(1);
            if (iss_last) run_cnt <= run_cnt + LEN_WIDTH'(1);
        end
    end

    // A run retiring on the same edge one is issued leaves the in-flight count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else if (abort_enter) begin
            outstanding <= '0;
        end else if (run_issued && !res_fire) begin
            outstanding <= outstanding + OW'(1);
        end else if (res_fire && !run_issued && outstanding != '0) begin
            outstanding <= outstanding - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_abort    <= 1'b0;
            err_spurious <= 1'b0;
        end else if (cfg_fire) begin
            err_abort    <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (abort_enter) err_abort <= 1'b1;
            if (res_fire && !run_issued && outstanding == '0) err_spurious <= 1'b1;
        end
    end

`ifdef PLPA_SEQ_PERF_EN
    logic [31:0] stall_cnt;
    logic        stall;

    assign stall = (state == S_ISSUE) & ((iss_valid & ~iss_ready) | at_limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (cfg_fire) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/plpa_run_sequencer.md
PLPA_RUN_SEQUENCER -- requirements
Module: plpa_run_sequencer

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16: width of beats-per-run and run-count fields.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: maximum number of runs issued but not yet retired, range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1), cfg_len (input, LEN_WIDTH) and cfg_runs (input, LEN_WIDTH): job command carrying beats per run (K) and number of runs (R).
REQ-006 SHALL have ports iss_valid (output, 1), iss_ready (input, 1), iss_last (output, 1) and iss_job_last (output, 1): per-beat issue token to the array's data and weight feeders; iss_last marks the final beat of a run, iss_job_last the final beat of the job.
REQ-007 SHALL have ports res_valid (input, 1), res_ready (input, 1) and res_last (input, 1): monitored partial-sum output handshake of the array.
REQ-008 SHALL have ports err_unalligned_data (input, 1) and core_rst (input, 1): array error and array internal reset.
REQ-009 SHALL have ports busy (output, 1), done (output, 1), err_abort (output, 1) and err_spurious (output, 1): status outputs.
REQ-010 SHALL have port perf_stall_cnt, output, 32: count of stalled cycles.

Function
REQ-011 SHALL implement the states IDLE, ISSUE, DRAIN, DONE and ABORT.
REQ-012 IDLE: cfg_ready=1; a cfg handshake with cfg_len>=1 and cfg_runs>=1 latches both values, clears the beat and run counters, and goes to ISSUE.
REQ-013 A cfg handshake with cfg_len=0 or cfg_runs=0 SHALL be accepted and SHALL produce a done pulse the next cycle with zero iss beats.
REQ-014 ISSUE: iss_valid=1 unless outstanding==MAX_OUTSTANDING; iss_valid, once asserted, SHALL NOT drop until the iss handshake completes, except on abort.
REQ-015 On each iss handshake the beat counter SHALL increment, and SHALL wrap to 0 on the beat where the count equals cfg_len-1.
REQ-016 iss_last SHALL be high exactly when beat count equals cfg_len-1; iss_job_last SHALL be high when iss_last is high and run count equals cfg_runs-1.
REQ-017 The run counter and outstanding SHALL increment on an iss handshake with iss_last=1; after the iss_job_last handshake the FSM SHALL go to DRAIN.
REQ-018 Outstanding SHALL decrement on res_valid&res_ready&res_last; on the same cycle as an issuing iss_last handshake it SHALL be unchanged.
REQ-019 A res_last handshake with outstanding==0 SHALL leave outstanding at 0 and set err_spurious, which is sticky until the next cfg handshake.
REQ-020 DRAIN: when outstanding reaches 0 the FSM SHALL go to DONE; DONE SHALL assert done for one cycle, then go to IDLE.
REQ-021 busy SHALL be 1 in ISSUE, DRAIN and ABORT; cfg_ready SHALL be 1 only in IDLE.
REQ-022 err_unalligned_data=1 or core_rst=1 in ISSUE or DRAIN SHALL move the FSM to ABORT next cycle, deassert iss_valid, clear outstanding and set err_abort.
REQ-023 err_abort SHALL be sticky until the next cfg handshake.
REQ-024 ABORT SHALL wait for core_rst=0 and err_unalligned_data=0 on the same cycle, then go to IDLE without pulsing done.
REQ-025 Issue latency SHALL be 1: iss_valid rises the cycle after the cfg handshake.
REQ-026 The module SHALL use no combinational path from iss_ready to iss_valid.

Reset
REQ-027 On rst low the block SHALL enter IDLE immediately, with counters=0, iss_valid=0, iss_last=0, iss_job_last=0, busy=0, done=0, err_abort=0, err_spurious=0, perf_stall_cnt=0 and cfg_ready=1 after release.
REQ-028 Reset asserted mid-job SHALL discard the job with no done pulse.

Configuration
REQ-029 With macro PLPA_SEQ_PERF_EN defined, perf_stall_cnt SHALL count ISSUE cycles with iss_valid&~iss_ready or outstanding==MAX_OUTSTANDING, saturating at 2^32-1 and clearing on a cfg handshake.
REQ-030 Without PLPA_SEQ_PERF_EN, perf_stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-031 Bench SHALL drive cfg_len=3, cfg_runs=2 with iss_ready=1 and results returned promptly -> 6 beats, iss_last on beats 3 and 6, iss_job_last on beat 6, one done pulse.
REQ-032 Bench SHALL set MAX_OUTSTANDING=2, cfg_len=1, cfg_runs=5 and withhold results -> iss_valid drops after 2 beats, then resumes one beat per returned res_last.
REQ-033 Bench SHALL align a res_last handshake with an iss_last handshake with outstanding=1 -> outstanding stays 1.
REQ-034 Bench SHALL pulse err_unalligned_data during beat 2 of a job with cfg_len=4 -> ABORT, iss_valid=0, err_abort=1, no done; a new cfg is accepted after the error clears.
REQ-035 Bench SHALL drive res_last with IDLE outstanding=0 -> err_spurious=1; then cfg_len=0 -> done next cycle, err_spurious cleared.
REQ-036 Bench SHALL apply rst low mid-DRAIN -> all outputs at reset values asynchronously; with PLPA_SEQ_PERF_EN, 3 iss_ready-low cycles -> perf_stall_cnt=3.
